// File: rtl/pid_sequencer.sv
// PID loop sequencer for the water-heater controller.
// Sample -> gain select -> PID handshake -> clamped heater duty.
module pid_sequencer #(
  parameter int               WIDTH     = 12,
  parameter int               PERIOD    = 100,
  parameter int               TIMEOUT   = 16,
  parameter logic [WIDTH-1:0] BAND      = 12'h020,
  parameter logic [WIDTH-1:0] KP_COARSE = 12'h010,
  parameter logic [WIDTH-1:0] KI_COARSE = 12'h000,
  parameter logic [WIDTH-1:0] KD_COARSE = 12'h004,
  parameter logic [WIDTH-1:0] KP_FINE   = 12'h008,
  parameter logic [WIDTH-1:0] KI_FINE   = 12'h002,
  parameter logic [WIDTH-1:0] KD_FINE   = 12'h008,
  parameter logic [WIDTH-1:0] DUTY_MAX  = 12'h3F0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enable,
  input  logic [WIDTH-1:0] setpoint,
  output logic             sensor_req,
  input  logic             sensor_valid,
  input  logic [WIDTH-1:0] sensor_data,
  output logic [WIDTH-1:0] pid_kp,
  output logic [WIDTH-1:0] pid_ki,
  output logic [WIDTH-1:0] pid_kd,
  output logic [WIDTH-1:0] pid_measured,
  output logic [WIDTH-1:0] pid_setpoint,
  input  logic [WIDTH-1:0] pid_response,
  input  logic             pid_computed,
  output logic [WIDTH-1:0] heater_duty,
  output logic             duty_valid,
  output logic             band_sel,
  output logic             busy,
  output logic             fault,
  output logic [7:0]       missed
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, WAIT, APPLY, FAULT
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pcnt;
  logic [TW-1:0]    r_tcnt;
  logic [WIDTH-1:0] r_meas;
  logic [WIDTH-1:0] r_resp;
  logic             r_comp_d;

  logic             w_tick;
  logic             w_tmo;
  logic             w_edge;
  logic [WIDTH:0]   w_err;
  logic [WIDTH:0]   w_abs;
  logic             w_coarse;
  logic [WIDTH-1:0] w_duty;

  assign w_tick   = enable && (r_pcnt == PW'(PERIOD - 1));
  assign w_tmo    = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_edge   = pid_computed && !r_comp_d;
  assign w_err    = {1'b0, setpoint} - {1'b0, r_meas};
  assign w_abs    = w_err[WIDTH] ? (~w_err + 1'b1) : w_err;
  assign w_coarse = (w_abs > {1'b0, BAND});

  // Saturate the signed PID response into the duty range.
  always_comb begin
    w_duty = r_resp;
    if (r_resp[WIDTH-1])
      w_duty = '0;
    else if (r_resp > DUTY_MAX)
      w_duty = DUTY_MAX;
  end

  // Free-running sample period counter, held at zero while disabled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_pcnt <= '0;
    else if (!enable || w_tick)
      r_pcnt <= '0;
    else
      r_pcnt <= r_pcnt + 1'b1;
  end

  // Count ticks that arrive while an iteration is still in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      missed <= '0;
    else if (w_tick && r_state != IDLE && missed != 8'hFF)
      missed <= missed + 1'b1;
  end

  // Previous pid_computed, so only a fresh rising edge is accepted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_comp_d <= 1'b0;
    else
      r_comp_d <= pid_computed;
  end

  // Iteration sequencer with registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_tcnt       <= '0;
      r_meas       <= '0;
      r_resp       <= '0;
      sensor_req   <= 1'b0;
      pid_kp       <= '0;
      pid_ki       <= '0;
      pid_kd       <= '0;
      pid_measured <= '0;
      pid_setpoint <= '0;
      heater_duty  <= '0;
      duty_valid   <= 1'b0;
      band_sel     <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (!enable) begin
        r_state      <= IDLE;
        r_tcnt       <= '0;
        sensor_req   <= 1'b0;
        pid_kp       <= '0;
        pid_ki       <= '0;
        pid_kd       <= '0;
        pid_measured <= '0;
        pid_setpoint <= '0;
        heater_duty  <= '0;
        band_sel     <= 1'b0;
        busy         <= 1'b0;
        fault        <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_tick) begin
              r_state    <= REQ;
              r_tcnt     <= '0;
              sensor_req <= 1'b1;
              busy       <= 1'b1;
            end
          end
          REQ: begin
            if (sensor_valid) begin
              r_meas     <= sensor_data;
              sensor_req <= 1'b0;
              r_state    <= LOAD;
            end else if (w_tmo) begin
              r_state     <= FAULT;
              sensor_req  <= 1'b0;
              busy        <= 1'b0;
              fault       <= 1'b1;
              heater_duty <= '0;
              pid_kp      <= '0;
              pid_ki      <= '0;
              pid_kd      <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          LOAD: begin
            band_sel     <= w_coarse;
            pid_kp       <= w_coarse ? KP_COARSE : KP_FINE;
            pid_ki       <= w_coarse ? KI_COARSE : KI_FINE;
            pid_kd       <= w_coarse ? KD_COARSE : KD_FINE;
            pid_measured <= r_meas;
            pid_setpoint <= setpoint;
            r_tcnt       <= '0;
            r_state      <= WAIT;
          end
          WAIT: begin
            if (w_edge) begin
              r_resp  <= pid_response;
              r_state <= APPLY;
            end else if (w_tmo) begin
              r_state     <= FAULT;
              busy        <= 1'b0;
              fault       <= 1'b1;
              heater_duty <= '0;
              pid_kp      <= '0;
              pid_ki      <= '0;
              pid_kd      <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          APPLY: begin
            heater_duty <= w_duty;
            duty_valid  <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end
          FAULT: begin
            r_state <= FAULT;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed self-checking bench for pid_sequencer.
// Second instance uses a short period to exercise tick overrun.
module tb_pid_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enable;
  logic [11:0] setpoint;
  logic        sensor_req;
  logic        sensor_valid;
  logic [11:0] sensor_data;
  logic [11:0] pid_kp, pid_ki, pid_kd;
  logic [11:0] pid_measured, pid_setpoint;
  logic [11:0] pid_response;
  logic        pid_computed;
  logic [11:0] heater_duty;
  logic        duty_valid, band_sel, busy, fault;
  logic [7:0]  missed;

  logic        enable2, sensor_valid2, pid_computed2;
  logic        sensor_req2;
  logic [11:0] kp2, ki2, kd2, meas2, sp2, heater2;
  logic        dv2, band2, busy2, fault2;
  logic [7:0]  missed2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  pid_sequencer u_dut (
    .CLK(CLK), .nRST(nRST), .enable(enable), .setpoint(setpoint),
    .sensor_req(sensor_req), .sensor_valid(sensor_valid),
    .sensor_data(sensor_data), .pid_kp(pid_kp), .pid_ki(pid_ki),
    .pid_kd(pid_kd), .pid_measured(pid_measured),
    .pid_setpoint(pid_setpoint), .pid_response(pid_response),
    .pid_computed(pid_computed), .heater_duty(heater_duty),
    .duty_valid(duty_valid), .band_sel(band_sel), .busy(busy),
    .fault(fault), .missed(missed)
  );

  pid_sequencer #(.PERIOD(20)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .enable(enable2), .setpoint(setpoint),
    .sensor_req(sensor_req2), .sensor_valid(sensor_valid2),
    .sensor_data(sensor_data), .pid_kp(kp2), .pid_ki(ki2),
    .pid_kd(kd2), .pid_measured(meas2), .pid_setpoint(sp2),
    .pid_response(pid_response), .pid_computed(pid_computed2),
    .heater_duty(heater2), .duty_valid(dv2), .band_sel(band2),
    .busy(busy2), .fault(fault2), .missed(missed2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sensor_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present one sample; returns with the DUT in WAIT.
  task automatic drive_sample(input logic [11:0] d, output bit ok);
    wait_req(ok);
    if (ok) begin
      sensor_data  = d;
      sensor_valid = 1'b1;
      step();
      sensor_valid = 1'b0;
      step();
    end
  endtask

  // Pulse pid_computed; returns when duty_valid should be high.
  task automatic drive_result(input logic [11:0] r);
    pid_response = r;
    pid_computed = 1'b1;
    step();
    pid_computed = 1'b0;
    step();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    step();
    step();
    n_cmp++;
    if (sensor_req !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl got req=%b busy=%b fault=%b want 0 0 0",
               sensor_req, busy, fault);
    end
    n_cmp++;
    if (heater_duty !== 12'h000 || duty_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_duty got %h/%b want 000/0", heater_duty, duty_valid);
    end
    n_cmp++;
    if (pid_kp !== 12'h000 || pid_ki !== 12'h000 || pid_kd !== 12'h000
        || missed !== 8'h00 || band_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_gains got kp=%h ki=%h kd=%h missed=%h want zeros",
               pid_kp, pid_ki, pid_kd, missed);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_tick();
    bit early;
    early    = 1'b0;
    setpoint = 12'h240;
    enable   = 1'b1;
    for (int i = 1; i < 100; i++) begin
      step();
      if (sensor_req !== 1'b0 || busy !== 1'b0 || duty_valid !== 1'b0
          || heater_duty !== 12'h000 || pid_kp !== 12'h000)
        early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL tick_early got activity=%b want 0", early);
    end
    step();
    n_cmp++;
    if (sensor_req !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL tick_req got req=%b busy=%b want 1 1", sensor_req, busy);
    end
  endtask

  task automatic test_coarse();
    bit ok;
    drive_sample(12'h182, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL coarse_req got timeout want sensor_req");
    end
    n_cmp++;
    if (band_sel !== 1'b1 || pid_kp !== 12'h010 || pid_ki !== 12'h000
        || pid_kd !== 12'h004) begin
      n_bad++;
      $display("FAIL coarse_gains got b=%b kp=%h ki=%h kd=%h want 1 010 000 004",
               band_sel, pid_kp, pid_ki, pid_kd);
    end
    n_cmp++;
    if (pid_measured !== 12'h182 || pid_setpoint !== 12'h240
        || busy !== 1'b1 || sensor_req !== 1'b0) begin
      n_bad++;
      $display("FAIL coarse_regs got m=%h s=%h busy=%b req=%b want 182 240 1 0",
               pid_measured, pid_setpoint, busy, sensor_req);
    end
    drive_result(12'h0BE);
    n_cmp++;
    if (duty_valid !== 1'b1 || heater_duty !== 12'h0BE) begin
      n_bad++;
      $display("FAIL coarse_duty got %b/%h want 1/0BE", duty_valid, heater_duty);
    end
    step();
    n_cmp++;
    if (duty_valid !== 1'b0 || busy !== 1'b0 || heater_duty !== 12'h0BE) begin
      n_bad++;
      $display("FAIL coarse_pulse got dv=%b busy=%b duty=%h want 0 0 0BE",
               duty_valid, busy, heater_duty);
    end
  endtask

  task automatic test_fine();
    bit ok;
    drive_sample(12'h228, ok);
    n_cmp++;
    if (ok !== 1'b1 || band_sel !== 1'b0 || pid_kp !== 12'h008
        || pid_ki !== 12'h002 || pid_kd !== 12'h008) begin
      n_bad++;
      $display("FAIL fine_gains got ok=%b b=%b kp=%h ki=%h kd=%h want 1 0 008 002 008",
               ok, band_sel, pid_kp, pid_ki, pid_kd);
    end
    drive_result(12'h010);
    n_cmp++;
    if (duty_valid !== 1'b1 || heater_duty !== 12'h010) begin
      n_bad++;
      $display("FAIL fine_duty got %b/%h want 1/010", duty_valid, heater_duty);
    end
    drive_sample(12'h220, ok);
    n_cmp++;
    if (ok !== 1'b1 || band_sel !== 1'b0 || pid_kp !== 12'h008) begin
      n_bad++;
      $display("FAIL fine_band_edge got ok=%b b=%b kp=%h want 1 0 008",
               ok, band_sel, pid_kp);
    end
    drive_result(12'h3F0);
    n_cmp++;
    if (duty_valid !== 1'b1 || heater_duty !== 12'h3F0) begin
      n_bad++;
      $display("FAIL fine_duty_max got %b/%h want 1/3F0", duty_valid, heater_duty);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    drive_sample(12'h182, ok);
    drive_result(12'hF80);
    n_cmp++;
    if (ok !== 1'b1 || duty_valid !== 1'b1 || heater_duty !== 12'h000) begin
      n_bad++;
      $display("FAIL clamp_neg got ok=%b dv=%b duty=%h want 1 1 000",
               ok, duty_valid, heater_duty);
    end
    drive_sample(12'h182, ok);
    drive_result(12'h7FF);
    n_cmp++;
    if (ok !== 1'b1 || duty_valid !== 1'b1 || heater_duty !== 12'h3F0) begin
      n_bad++;
      $display("FAIL clamp_pos got ok=%b dv=%b duty=%h want 1 1 3F0",
               ok, duty_valid, heater_duty);
    end
  endtask

  task automatic test_timeout_req();
    bit ok;
    wait_req(ok);
    repeat (15) step();
    n_cmp++;
    if (ok !== 1'b1 || fault !== 1'b0 || sensor_req !== 1'b1) begin
      n_bad++;
      $display("FAIL treq_early got ok=%b fault=%b req=%b want 1 0 1",
               ok, fault, sensor_req);
    end
    step();
    n_cmp++;
    if (fault !== 1'b1 || sensor_req !== 1'b0 || busy !== 1'b0
        || heater_duty !== 12'h000) begin
      n_bad++;
      $display("FAIL treq_fault got fault=%b req=%b busy=%b duty=%h want 1 0 0 000",
               fault, sensor_req, busy, heater_duty);
    end
    step();
    n_cmp++;
    if (fault !== 1'b1) begin
      n_bad++;
      $display("FAIL treq_sticky got fault=%b want 1", fault);
    end
    enable = 1'b0;
    step();
    n_cmp++;
    if (fault !== 1'b0 || busy !== 1'b0 || sensor_req !== 1'b0) begin
      n_bad++;
      $display("FAIL treq_clear got fault=%b busy=%b req=%b want 0 0 0",
               fault, busy, sensor_req);
    end
    enable = 1'b1;
  endtask

  task automatic test_timeout_wait();
    bit ok;
    drive_sample(12'h182, ok);
    drive_result(12'h0BE);
    pid_computed = 1'b1;
    drive_sample(12'h182, ok);
    repeat (15) step();
    n_cmp++;
    if (ok !== 1'b1 || fault !== 1'b0 || busy !== 1'b1 || duty_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL twait_early got ok=%b fault=%b busy=%b dv=%b want 1 0 1 0",
               ok, fault, busy, duty_valid);
    end
    step();
    n_cmp++;
    if (fault !== 1'b1 || heater_duty !== 12'h000 || pid_kp !== 12'h000
        || pid_kd !== 12'h000) begin
      n_bad++;
      $display("FAIL twait_fault got fault=%b duty=%h kp=%h kd=%h want 1 000 000 000",
               fault, heater_duty, pid_kp, pid_kd);
    end
    pid_computed = 1'b0;
    enable       = 1'b0;
    step();
    n_cmp++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL twait_clear got fault=%b busy=%b want 0 0", fault, busy);
    end
    enable = 1'b1;
  endtask

  task automatic test_abort();
    bit ok;
    drive_sample(12'h228, ok);
    n_cmp++;
    if (ok !== 1'b1 || pid_kp !== 12'h008 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre got ok=%b kp=%h busy=%b want 1 008 1",
               ok, pid_kp, busy);
    end
    enable       = 1'b0;
    pid_computed = 1'b1;
    pid_response = 12'h100;
    step();
    n_cmp++;
    if (busy !== 1'b0 || pid_kp !== 12'h000 || pid_ki !== 12'h000
        || pid_kd !== 12'h000 || sensor_req !== 1'b0 || duty_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle got busy=%b kp=%h ki=%h kd=%h req=%b dv=%b want zeros",
               busy, pid_kp, pid_ki, pid_kd, sensor_req, duty_valid);
    end
    pid_computed = 1'b0;
    step();
    n_cmp++;
    if (duty_valid !== 1'b0 || heater_duty !== 12'h000) begin
      n_bad++;
      $display("FAIL abort_nodv got %b/%h want 0/000", duty_valid, heater_duty);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    ok      = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sensor_req2 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_req got timeout want sensor_req");
    end
    repeat (8) step();
    sensor_data   = 12'h182;
    sensor_valid2 = 1'b1;
    step();
    sensor_valid2 = 1'b0;
    step();
    n_cmp++;
    if (missed2 !== 8'h00 || busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_pre got missed=%0d busy=%b want 0 1", missed2, busy2);
    end
    repeat (11) step();
    n_cmp++;
    if (missed2 !== 8'h01 || fault2 !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_missed got missed=%0d fault=%b want 1 0", missed2, fault2);
    end
    pid_response  = 12'h055;
    pid_computed2 = 1'b1;
    step();
    pid_computed2 = 1'b0;
    step();
    n_cmp++;
    if (dv2 !== 1'b1 || heater2 !== 12'h055) begin
      n_bad++;
      $display("FAIL ovr_duty got %b/%h want 1/055", dv2, heater2);
    end
    enable2 = 1'b0;
    step();
    n_cmp++;
    if (missed2 !== 8'h01 || missed !== 8'h00) begin
      n_bad++;
      $display("FAIL ovr_hold got missed2=%0d missed=%0d want 1 0", missed2, missed);
    end
  endtask

  initial begin
    nRST          = 1'b0;
    enable        = 1'b0;
    setpoint      = 12'h000;
    sensor_valid  = 1'b0;
    sensor_data   = 12'h000;
    pid_response  = 12'h000;
    pid_computed  = 1'b0;
    enable2       = 1'b0;
    sensor_valid2 = 1'b0;
    pid_computed2 = 1'b0;
    test_reset();
    test_tick();
    test_coarse();
    test_fine();
    test_clamp();
    test_timeout_req();
    test_timeout_wait();
    test_abort();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
Sequences one PID loop iteration per sample period for the water-heater controller.
- Requests a temperature sample from the sensor interface.
- Selects a coarse or fine gain set based on the error magnitude and drives the PID datapath inputs.
- Waits for the PID `computed` flag, then converts the signed response into a clamped heater duty command.
- Sits between the sensor front end, the PID block and the heater PWM stage.

Parameters:
WIDTH, 12, datapath width; all values are Q8.4 fixed point
PERIOD, 100, clock cycles between sample ticks
TIMEOUT, 16, maximum cycles to wait for sensor_valid or for PID completion
BAND, 12'h020, error threshold (2.0); |error| > BAND selects the coarse gains
KP_COARSE / KI_COARSE / KD_COARSE, 12'h010 / 12'h000 / 12'h004, coarse gains (1.0 / 0 / 0.25)
KP_FINE / KI_FINE / KD_FINE, 12'h008 / 12'h002 / 12'h008, fine gains (0.5 / 0.125 / 0.5)
DUTY_MAX, 12'h3F0, heater duty ceiling (63.0)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
enable  in  1  loop run; low aborts the cycle and clears the fault
setpoint  in  WIDTH  target temperature, unsigned Q8.4
sensor_req  out  1  sample request, held until sensor_valid
sensor_valid  in  1  sensor_data valid; accepted only while sensor_req=1
sensor_data  in  WIDTH  measured temperature, unsigned Q8.4
pid_kp / pid_ki / pid_kd  out  WIDTH  signed gains to the PID block
pid_measured  out  WIDTH  registered measured value to the PID block
pid_setpoint  out  WIDTH  registered setpoint to the PID block
pid_response  in  WIDTH  signed PID output
pid_computed  in  1  PID result-valid flag
heater_duty  out  WIDTH  clamped duty command
duty_valid  out  1  one-cycle pulse when heater_duty updates
band_sel  out  1  0 = fine gains, 1 = coarse gains
busy  out  1  high in every state except IDLE and FAULT
fault  out  1  sticky timeout flag
missed  out  8  saturating count of ticks dropped while busy

Behaviour:
Reset and tick generation:
- On reset, every output is 0, the FSM is in IDLE, and the period and timeout counters are 0.
- The period counter runs only while enable=1 and issues a tick every PERIOD cycles; the first tick comes PERIOD cycles after enable rises.
- A tick outside IDLE is dropped and increments `missed`, which saturates at 255.

FSM states: IDLE -> REQ -> LOAD -> WAIT -> APPLY -> IDLE, plus FAULT.
- **IDLE:** on a tick, go to REQ; sensor_req rises the following cycle.
- **REQ:** sensor_req=1. On sensor_valid, capture sensor_data, drop sensor_req and go to LOAD. If TIMEOUT cycles pass without sensor_valid, go to FAULT.
- **LOAD (1 cycle):**
  - error = setpoint - measured, computed as a 13-bit signed value.
  - band_sel = (|error| > BAND); |error| == BAND selects fine.
  - Register pid_kp/ki/kd from the selected set, plus pid_measured and pid_setpoint.
- **WAIT:**
  - A result is accepted only on a 0->1 transition of pid_computed sampled inside WAIT; a flag still high on entry is stale.
  - No accepted edge within TIMEOUT cycles -> FAULT.
- **APPLY (1 cycle):**
  - heater_duty = 0 if pid_response < 0; DUTY_MAX if pid_response > DUTY_MAX; otherwise pid_response.
  - duty_valid pulses for 1 cycle, then return to IDLE.
- **FAULT:** fault=1, heater_duty=0, sensor_req=0, gains=0. Leave only when enable goes low, which returns to IDLE and clears fault.

Enable and timing rules:
- enable=0 in any state forces IDLE on the next edge: sensor_req=0, gains=0, heater_duty=0, period counter cleared. `missed` holds its value.
- Latency from sensor_valid to duty_valid is 3 + (cycles to the pid_computed edge).
- sensor_valid arriving together with a timeout expiry: the data wins.
- sensor_valid outside REQ is ignored.

Test Plan:
1. Reset, then enable=1 with setpoint=12'h240 -> sensor_req rises on cycle 100 after enable; all outputs were 0 up to that point.
2. Coarse band: sensor_data=12'h182 (24.125), error=12'h0BE -> band_sel=1, pid_kp=12'h010, pid_kd=12'h004. Then pid_response=12'h0BE -> heater_duty=12'h0BE, one duty_valid pulse.
3. Fine band: sensor_data=12'h228, error=12'h018 -> band_sel=0, pid_kp=12'h008, pid_ki=12'h002. Also check sensor_data=12'h220 (|error| == BAND) -> band_sel=0.
4. Clamping: pid_response=12'h7FF -> heater_duty=12'h3F0. pid_response=12'hF80 (negative) -> heater_duty=0.
5. Timeouts: hold sensor_valid=0 for 16 cycles in REQ -> fault=1, heater_duty=0. Same result with pid_computed stuck high through WAIT. Dropping enable clears fault and returns to IDLE.
6. Abort and overrun:
   - Drop enable mid-WAIT -> IDLE next cycle, gains=0, no duty_valid.
   - Stall WAIT across a tick -> missed increments by 1.
